// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches one word at a
// time from instruction memory over a req/ack handshake, presents it to
// decode over valid/ready, applies decode's redirects on the consume edge,
// and traps misaligned redirects and fetch timeouts into a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] address_from_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        addr_sel_for_pc,
  input  logic [31:0] address_to_pc_from_control,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] retired_count
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES; keep at least 1 bit
  // so a disabled timeout still elaborates cleanly.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_LAST_I);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_fault_addr;
  logic [31:0]   r_retired;
  logic          r_req;
  logic          r_valid;
  logic          r_fault;
  logic [CW-1:0] r_tmo;

  logic          w_redir_bad;
  logic [31:0]   w_pc_next;
  logic          w_tmo_hit;

  // A redirect is misaligned when its low two bits are set; they are never
  // masked, so the offending target is reported verbatim.
  assign w_redir_bad = addr_sel_for_pc && (address_to_pc_from_control[1:0] != 2'b00);
  assign w_pc_next   = addr_sel_for_pc ? address_to_pc_from_control : (r_pc + 32'd4);
  // The no-ack edge that would bring the count to TIMEOUT_CYCLES is the fault edge.
  assign w_tmo_hit   = TMO_EN && (r_tmo == TMO_LAST);

  // Fetch FSM: all outputs are registered and updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0;
      r_fault_addr <= 32'h0;
      r_retired    <= 32'h0;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_tmo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_tmo   <= '0;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_HOLD;
          end else if (w_tmo_hit) begin
            r_fault_addr <= r_pc;
            r_fault      <= 1'b1;
            r_req        <= 1'b0;
            r_state      <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + CW'(1);
          end
        end
        S_HOLD: begin
          // Redirect inputs only matter on the consume edge.
          if (instr_ready) begin
            r_retired <= r_retired + 32'd1;
            r_valid   <= 1'b0;
            if (w_redir_bad) begin
              r_fault_addr <= address_to_pc_from_control;
              r_fault      <= 1'b1;
              r_state      <= S_FAULT;
            end else begin
              r_pc    <= w_pc_next;
              r_req   <= 1'b1;
              r_tmo   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          // Sticky until reset; PC stays frozen at the faulting context.
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req        = r_req;
  assign imem_addr       = r_pc;
  assign address_from_pc = r_pc;
  assign instruction     = r_instr;
  assign instr_valid     = r_valid;
  assign fault           = r_fault;
  assign fault_addr      = r_fault_addr;
  assign retired_count   = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory latency / decode backpressure /
// redirects against a PC-sequence reference model with a scoreboard, plus
// directed fault, timeout, async-reset and PC-wrap scenarios.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: RESET_PC=0, TIMEOUT_CYCLES=16
  logic        rst = 1'b1, imem_ack = 1'b0, instr_ready = 1'b0, sel = 1'b0;
  logic [31:0] imem_rdata = 32'h0, tgt = 32'h0;
  logic        imem_req, instr_valid, fault;
  logic [31:0] imem_addr, instruction, afp, fault_addr, retired;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .address_from_pc(afp), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .addr_sel_for_pc(sel), .address_to_pc_from_control(tgt), .fault(fault),
    .fault_addr(fault_addr), .retired_count(retired)
  );

  // wrap DUT: RESET_PC at top of address space, timeout disabled
  logic        rst2 = 1'b1, ack2 = 1'b0, ready2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        req2, valid2, fault2;
  logic [31:0] addr2, instr2, afp2, faddr2, ret2;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instruction(instr2),
    .address_from_pc(afp2), .instr_valid(valid2), .instr_ready(ready2),
    .addr_sel_for_pc(1'b0), .address_to_pc_from_control(32'h0), .fault(fault2),
    .fault_addr(faddr2), .retired_count(ret2)
  );

  int vectors = 0, miscompares = 0, n_seen = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // reference model state: PC of the next instruction decode will see
  logic [31:0] m_pc, m_ret;
  bit rand_dec = 0, mem_on = 0, mem_busy = 0, mon_en = 0, prev_v = 0;
  int lat_left = 0;

  // memory contents are a fixed function of the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ret);
    exp_t e;
    e.pc = pc; e.instr = memf(pc); e.ret = ret;
    exp_q.push_back(e);
  endtask

  // one cycle of environment: memory responder plus decode
  task automatic step();
    @(negedge clk);
    if (imem_req && mem_on) begin
      if (!mem_busy) begin
        mem_busy = 1;
        lat_left = $urandom_range(0, 6);
      end
      if (lat_left == 0) begin
        imem_ack = 1'b1; imem_rdata = memf(imem_addr); mem_busy = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; lat_left--;
      end
    end else begin
      // stray acks outside a request must be ignored
      imem_ack   = imem_req ? 1'b0 : 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    instr_ready = 1'b0;
    sel = 1'($urandom_range(0, 1));
    tgt = $urandom;
    if (rand_dec && instr_valid && ($urandom_range(0, 2) != 0)) begin
      instr_ready = 1'b1;
      sel = ($urandom_range(0, 3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      m_ret = m_ret + 1;
      m_pc  = sel ? tgt : m_pc + 32'd4;
      push_exp(m_pc, m_ret);
    end
  endtask

  task automatic do_reset();
    mon_en = 0; rand_dec = 0; mem_on = 0; mem_busy = 0;
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_pc = 32'h0; m_ret = 32'h0;
    push_exp(m_pc, m_ret);
    rst = 1'b0; mon_en = 1;
  endtask

  // monitor: each newly presented instruction must match the oldest prediction
  always @(negedge clk) begin
    if (mon_en && instr_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_instr: got pc %h, none expected", afp);
      end else begin
        mon_e = exp_q.pop_front();
        n_seen++;
        chk("pc", afp, mon_e.pc);
        chk("instr", instruction, mon_e.instr);
        chk("retired", retired, mon_e.ret);
      end
    end
    prev_v = instr_valid;
  end

  initial begin
    int n, n_req;
    logic [31:0] pc_hold;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);

    // randomized traffic
    do_reset();
    rand_dec = 1; mem_on = 1;
    repeat (400) step();
    chk("enough_instrs", 32'(n_seen > 40), 32'h1);

    // misaligned redirect on consume -> sticky fault
    rand_dec = 0;
    n = 0;
    do begin step(); n++; end while (!instr_valid && n < 50);
    chk("wait_hold", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1; sel = 1'b1; tgt = 32'h0000_0042;
    @(posedge clk); #1;
    mon_en = 0; instr_ready = 1'b0; sel = 1'b0;
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_fault_addr", fault_addr, 32'h0000_0042);
    chk("mis_valid", {31'h0, instr_valid}, 32'h0);
    chk("mis_retired", retired, m_ret + 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fault_no_req", {31'h0, imem_req}, 32'h0);
    end
    chk("fault_sticky", {31'h0, fault}, 32'h1);
    chk("fault_pc_frozen", afp, m_pc);

    // fetch timeout
    do_reset();
    n = 0; n_req = 0;
    while (n < 40) begin
      step(); n++;
      if (fault) break;
      if (imem_req) n_req++;
    end
    chk("tmo_req_cycles", n_req, 32'd16);
    chk("tmo_fault", {31'h0, fault}, 32'h1);
    chk("tmo_fault_addr", fault_addr, 32'h0);
    chk("tmo_req_low", {31'h0, imem_req}, 32'h0);

    // async reset in the middle of a request, ack during reset ignored
    do_reset();
    rand_dec = 1; mem_on = 1;
    repeat (60) step();
    rand_dec = 0; mem_on = 0;
    n = 0;
    do begin step(); n++; end while (!imem_req && n < 50);
    chk("wait_req", {31'h0, imem_req}, 32'h1);
    chk("req_pc", imem_addr, m_pc);
    step(); step();
    @(posedge clk); #2;
    mon_en = 0; rst = 1'b1;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_pc", imem_addr, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("arst_ack_ign_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_ack_ign_instr", instruction, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0; mem_busy = 0;
    exp_q.delete(); m_pc = 32'h0; m_ret = 32'h0; push_exp(m_pc, m_ret);
    rst = 1'b0; mon_en = 1; rand_dec = 1; mem_on = 1;
    pc_hold = 32'(n_seen);
    repeat (80) step();
    chk("post_rst_instrs", 32'(n_seen > pc_hold + 3), 32'h1);
    mon_en = 0; rand_dec = 0;

    // PC wrap from 0xFFFF_FFFC, timeout disabled
    @(negedge clk); rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_req", {31'h0, req2}, 32'h1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; rdata2 = 32'h0050_0093;
    @(negedge clk);
    ack2 = 1'b0;
    chk("wrap_valid", {31'h0, valid2}, 32'h1);
    chk("wrap_instr", instr2, 32'h0050_0093);
    chk("wrap_afp", afp2, 32'hFFFF_FFFC);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    chk("wrap_next_addr", addr2, 32'h0);
    chk("wrap_next_req", {31'h0, req2}, 32'h1);
    chk("wrap_retired", ret2, 32'h1);
    repeat (40) @(negedge clk);
    chk("no_tmo_fault", {31'h0, fault2}, 32'h0);
    chk("no_tmo_req", {31'h0, req2}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control stage.
- Owns the program counter and fetches instructions from instruction memory over a req/ack handshake with variable latency.
- Presents one instruction plus its PC to decode through a valid/ready handshake.
- Applies PC redirects (taken branch, JAL, JALR) that decode returns, and traps misaligned redirects and fetch timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
TIMEOUT_CYCLES, 16, max cycles in REQ without imem_ack before fault; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals pc.
imem_ack  input  1  memory returns data this cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
instruction  output  32  registered instruction word to decode.
address_from_pc  output  32  PC of the presented instruction.
instr_valid  output  1  instruction/address_from_pc valid.
instr_ready  input  1  decode consumes the instruction this cycle.
addr_sel_for_pc  input  1  redirect request from decode.
address_to_pc_from_control  input  32  redirect target.
fault  output  1  sticky fetch fault.
fault_addr  output  32  offending address.
retired_count  output  32  count of consumed instructions.

Behaviour:
Reset values (async, while rst=1):
- State=IDLE; pc=RESET_PC; imem_req=0; instr_valid=0; instruction=0; fault=0; fault_addr=0; retired_count=0; timeout counter=0.
- Asserting rst in any state aborts immediately. An outstanding request is dropped, and a late imem_ack is ignored.

States:
- IDLE: first clk edge with rst=0 -> REQ.
- REQ:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On an edge with imem_ack=1: instruction<=imem_rdata; instr_valid<=1; timeout counter<=0; -> HOLD.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES (nonzero) without ack: fault_addr<=pc; -> FAULT.
- HOLD:
  - imem_req=0; instr_valid=1; instruction and address_from_pc stable.
  - On an edge with instr_ready=1:
    - retired_count increments, wrapping mod 2^32.
    - If addr_sel_for_pc=1 and address_to_pc_from_control[1:0]==0: pc<=address_to_pc_from_control.
    - If addr_sel_for_pc=1 and address_to_pc_from_control[1:0]!=0: fault_addr<=address_to_pc_from_control; -> FAULT.
    - Else pc<=pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
    - instr_valid<=0; -> REQ unless faulting.
  - instr_ready=0: hold everything; addr_sel_for_pc is ignored.
- FAULT:
  - fault=1; imem_req=0; instr_valid=0; pc frozen.
  - Leaves only on rst.

Rules:
- address_from_pc always equals pc; pc changes only on a HOLD->REQ transition.
- imem_ack outside REQ is ignored; imem_rdata is sampled only on ack in REQ.
- Redirects are honoured only on the consume edge (instr_valid & instr_ready). The redirect target's low 2 bits are not masked.
- Throughput: minimum 2 cycles per instruction (1 REQ with zero-wait ack + 1 HOLD with ready).
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter clears on every REQ entry.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093 at addr 0, instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; retired_count=3 after third consume.
- Memory ack delayed 5 cycles at addr 0 -> imem_req high for 6 cycles with imem_addr=0 constant; instruction captured on ack; instr_valid stays high with instr_ready=0 for 3 cycles; pc does not advance.
- Consume at pc=8 with addr_sel_for_pc=1, target 32'h0000_0040 -> next imem_addr=32'h40; address_from_pc=32'h40 on next HOLD; no fault.
- Redirect target 32'h0000_0042 -> fault=1 and fault_addr=32'h42 next cycle; imem_req stays 0 indefinitely; only rst clears fault.
- TIMEOUT_CYCLES=16, no ack -> fault rises after 16 REQ cycles with fault_addr=pc. Assert rst mid-REQ on a separate run -> imem_req drops asynchronously, pc=RESET_PC, and an ack pulse during reset is ignored.
- RESET_PC=32'hFFFF_FFFC, consume without redirect -> next imem_addr=32'h0000_0000 (wrap).
